// File: rtl/stream_to_hs_adapter.sv
// AXI-Stream to ap_hs adapter: DEPTH-entry FIFO packing {tdata, tid, tlast} into a 72-bit word.
// Optional STREAM_TO_HS_TDEST_CHECK_EN discards beats whose tdest differs from accID.
module stream_to_hs_adapter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [4:0]  accID,
  input  logic [63:0] inStream_tdata,
  input  logic [4:0]  inStream_tid,
  input  logic [4:0]  inStream_tdest,
  input  logic        inStream_tlast,
  input  logic        inStream_tvalid,
  output logic        inStream_tready,
  output logic [71:0] out_hs,
  output logic        out_hs_ap_vld,
  input  logic        out_hs_ap_ack,
  output logic [6:0]  level,
  output logic [15:0] drop_count
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]  DEPTH_L = 7'(DEPTH);

  logic [71:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [6:0]    level_q;
  logic          accept;
  logic          dest_ok;
  logic          wr_en;
  logic          pop;

  assign inStream_tready = (level_q < DEPTH_L);
  assign out_hs_ap_vld   = (level_q != '0);
  assign out_hs          = mem[rd_ptr];
  assign level           = level_q;

  assign accept = inStream_tvalid && inStream_tready;
  assign wr_en  = accept && dest_ok;
  assign pop    = out_hs_ap_vld && out_hs_ap_ack;

`ifdef STREAM_TO_HS_TDEST_CHECK_EN
  logic [15:0] drop_q;

  assign dest_ok    = (inStream_tdest == accID);
  assign drop_count = drop_q;

  // Rejected beats are still handshaken so the upstream never stalls on them.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      drop_q <= '0;
    end else if (accept && !dest_ok && (drop_q != '1)) begin
      drop_q <= drop_q + 16'd1;
    end
  end
`else
  logic unused_dest;

  assign dest_ok     = 1'b1;
  assign drop_count  = '0;
  assign unused_dest = ^{inStream_tdest, accID};
`endif

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + 7'd1;
        2'b01:   level_q <= level_q - 7'd1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aresetn && wr_en) begin
      mem[wr_ptr] <= {inStream_tdata, 1'b0, inStream_tid, 1'b0, inStream_tlast};
    end
  end

endmodule

// File: tb/tb_stream_to_hs_adapter.sv
// Scoreboard bench for stream_to_hs_adapter (DEPTH=4); honours STREAM_TO_HS_TDEST_CHECK_EN.
module tb_stream_to_hs_adapter;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [4:0]  accID = 5'd2;
  logic [63:0] tdata = '0;
  logic [4:0]  tid = '0;
  logic [4:0]  tdest = 5'd2;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [71:0] out_hs;
  logic        vld;
  logic        ack = 1'b0;
  logic [6:0]  level;
  logic [15:0] drop_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned out_cnt = 0;
  int unsigned m_level = 0;
  int unsigned m_drops = 0;
  logic [71:0] exp_q [$];

  stream_to_hs_adapter #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .accID           (accID),
    .inStream_tdata  (tdata),
    .inStream_tid    (tid),
    .inStream_tdest  (tdest),
    .inStream_tlast  (tlast),
    .inStream_tvalid (tvalid),
    .inStream_tready (tready),
    .out_hs          (out_hs),
    .out_hs_ap_vld   (vld),
    .out_hs_ap_ack   (ack),
    .level           (level),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle, predicts what the next rising edge does.
  always @(negedge clk) begin
    logic acc, pop, wr;
    logic [71:0] e;
    if (!aresetn) begin
      exp_q.delete();
      m_level = 0;
      m_drops = 0;
    end else begin
      check("level", {65'd0, level}, 72'(m_level));
      check("tready", {71'd0, tready}, 72'(m_level < DEPTH));
      check("vld", {71'd0, vld}, 72'(m_level != 0));
      check("drops", {56'd0, drop_count}, 72'(m_drops));
      acc = tvalid && (m_level < DEPTH);
      pop = (m_level != 0) && ack;
`ifdef STREAM_TO_HS_TDEST_CHECK_EN
      wr = acc && (tdest == accID);
      if (acc && !wr && m_drops < 16'hFFFF) m_drops++;
`else
      wr = acc;
`endif
      if (pop) begin
        out_cnt++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("data", out_hs, e);
        end else begin
          check("sb_empty", {71'd0, vld}, 72'd0);
        end
      end
      if (wr) exp_q.push_back({tdata, 1'b0, tid, 1'b0, tlast});
      m_level = m_level + (wr ? 1 : 0) - (pop ? 1 : 0);
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [63:0] d, input logic [4:0] id, input logic [4:0] dst,
                      input logic last, input int unsigned budget);
    logic ok;
    ok = 1'b0;
    tdata = d; tid = id; tdest = dst; tlast = last; tvalid = 1'b1;
    for (int unsigned n = 0; n < budget; n++) begin
      @(negedge clk);
      ok = tready;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) check("send_accept", {71'd0, ok}, 72'd1);
    tvalid = 1'b0;
  endtask

  task automatic drain(input int unsigned budget);
    for (int unsigned n = 0; n < budget; n++) begin
      @(negedge clk);
      if (level == 0) break;
    end
    check("drain", {65'd0, level}, 72'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned t0, o0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    @(negedge clk);
    check("rst_tready", {71'd0, tready}, 72'd1);
    check("rst_vld", {71'd0, vld}, 72'd0);
    check("rst_level", {65'd0, level}, 72'd0);
    @(posedge clk); #1;

    // Single beat, one-cycle latency
    ack = 1'b1;
    send(64'h1122334455667788, 5'd3, 5'd2, 1'b1, 20);
    @(negedge clk);
    check("single_vld", {71'd0, vld}, 72'd1);
    check("single_hs", out_hs, 72'h1122334455667788_0D);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_empty", {65'd0, level}, 72'd0);
    @(posedge clk); #1;

    // Overfill with ack low, then release
    ack = 1'b0;
    fork
      for (int unsigned i = 0; i < 6; i++)
        send({32'hA000_0000 + 32'(i), $urandom}, 5'(i), 5'd2, (i == 5), 60);
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("full_level", {65'd0, level}, 72'd4);
        check("full_tready", {71'd0, tready}, 72'd0);
        @(posedge clk); #1;
        ack = 1'b1;
      end
    join
    drain(30);

    // Back-to-back stream with ack held high
    ack = 1'b1;
    t0 = cyc;
    for (int unsigned i = 0; i < 8; i++)
      send({$urandom, $urandom}, 5'(i + 8), 5'd2, (i == 7), 20);
    check("stream_cycles", 72'(cyc - t0), 72'd8);
    drain(20);

    // Push offered at full in the same cycle as a pop
    ack = 1'b0;
    for (int unsigned i = 0; i < 4; i++) send({$urandom, $urandom}, 5'(i), 5'd2, 1'b0, 20);
    tdata = 64'hDEAD_BEEF_0000_0036; tid = 5'd9; tdest = 5'd2; tlast = 1'b1;
    tvalid = 1'b1; ack = 1'b1;
    @(negedge clk);
    check("pp_tready_full", {71'd0, tready}, 72'd0);
    check("pp_level4", {65'd0, level}, 72'd4);
    @(posedge clk); #1 ack = 1'b0;
    @(negedge clk);
    check("pp_level3", {65'd0, level}, 72'd3);
    check("pp_tready", {71'd0, tready}, 72'd1);
    @(posedge clk); #1 tvalid = 1'b0;
    @(negedge clk);
    check("pp_level4b", {65'd0, level}, 72'd4);
    @(posedge clk); #1 ack = 1'b1;
    drain(20);

    // Destination filtering
    ack = 1'b1;
    o0 = out_cnt;
    send(64'h0000_0000_0000_0A02, 5'd1, 5'd2, 1'b0, 20);
    send(64'h0000_0000_0000_0A05, 5'd1, 5'd5, 1'b0, 20);
    send(64'h0000_0000_0000_0B02, 5'd1, 5'd2, 1'b1, 20);
    drain(20);
`ifdef STREAM_TO_HS_TDEST_CHECK_EN
    check("dest_outputs", 72'(out_cnt - o0), 72'd2);
    check("dest_drops", {56'd0, drop_count}, 72'd1);
`else
    check("dest_outputs", 72'(out_cnt - o0), 72'd3);
    check("dest_drops", {56'd0, drop_count}, 72'd0);
`endif

    // Reset with entries in flight
    ack = 1'b0;
    for (int unsigned i = 0; i < 3; i++) send({$urandom, $urandom}, 5'(i), 5'd2, 1'b0, 20);
    @(negedge clk);
    check("pre_rst_level", {65'd0, level}, 72'd3);
    @(posedge clk); #1 aresetn = 1'b0; ack = 1'b1;
    @(posedge clk); #1 aresetn = 1'b1;
    @(negedge clk);
    check("rst2_vld", {71'd0, vld}, 72'd0);
    check("rst2_level", {65'd0, level}, 72'd0);
    check("rst2_tready", {71'd0, tready}, 72'd1);
    @(posedge clk); #1;
    send(64'h0123_4567_89AB_CDEF, 5'd7, 5'd2, 1'b1, 20);
    drain(20);

    check("sb_left", 72'(exp_q.size()), 72'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stream_to_hs_adapter.md
STREAM_TO_HS_ADAPTER -- requirements
Module: stream_to_hs_adapter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port accID  input  5  accelerator ID, static after reset.
REQ-005 SHALL have port inStream_tdata  input  64  beat payload.
REQ-006 SHALL have port inStream_tid  input  5  source ID of beat.
REQ-007 SHALL have port inStream_tdest  input  5  destination ID of beat.
REQ-008 SHALL have port inStream_tlast  input  1  last beat of message.
REQ-009 SHALL have port inStream_tvalid  input  1  beat valid.
REQ-010 SHALL have port inStream_tready  output  1  adapter accepts beat.
REQ-011 SHALL have port out_hs  output  72  packed word to accelerator.
REQ-012 SHALL have port out_hs_ap_vld  output  1  out_hs valid.
REQ-013 SHALL have port out_hs_ap_ack  input  1  accelerator consumed out_hs.
REQ-014 SHALL have port level  output  7  current FIFO occupancy, 0..DEPTH.
REQ-015 SHALL have port drop_count  output  16  beats discarded by destination check.

Function
REQ-016 SHALL pack each entry as out_hs[71:8]=tdata, [6:2]=tid, [0]=tlast, [7]=0, [1]=0.
REQ-017 SHALL drive inStream_tready = (level < DEPTH), combinational from registered level only.
REQ-018 SHALL accept a beat on clock edge where tvalid && tready.
REQ-019 SHALL write an accepted beat into the FIFO tail unless discarded per REQ-031.
REQ-020 SHALL drive out_hs_ap_vld = (level != 0); out_hs = FIFO head entry.
REQ-021 SHALL pop the head on clock edge where out_hs_ap_vld && out_hs_ap_ack; ack while vld low ignored.
REQ-022 SHALL have latency 1 cycle: a beat written at edge N appears as out_hs_ap_vld at N+1 when FIFO empty.
REQ-023 SHALL hold out_hs stable while out_hs_ap_vld high and no pop.
REQ-024 SHALL on simultaneous write and pop keep level unchanged and preserve order.
REQ-025 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated entries.
REQ-026 SHALL deassert tready when full; pop at full raises tready next cycle (no same-cycle pass-through).
REQ-027 SHALL sustain one beat per cycle when not full and ack held high.

Reset
REQ-028 SHALL on aresetn low at an edge clear level, pointers, drop_count; FIFO contents undefined.
REQ-029 SHALL output after reset: tready=1, out_hs_ap_vld=0, level=0, drop_count=0; in-flight entries discarded.
REQ-030 SHALL ignore tvalid and out_hs_ap_ack in any cycle aresetn is low.

Configuration
REQ-031 SHALL with macro STREAM_TO_HS_TDEST_CHECK_EN defined, accept-and-discard beats with tdest != accID (not written), increment drop_count saturating at 0xFFFF.
REQ-032 SHALL without STREAM_TO_HS_TDEST_CHECK_EN, write every accepted beat, ignore tdest, tie drop_count to 0.

Verification
REQ-033 SHALL cover: reset, one beat tdata=0x1122334455667788 tid=3 tlast=1, ack=1 -> vld at next cycle, out_hs=0x1122334455667788_0D, level returns 0.
REQ-034 SHALL cover: DEPTH=4, ack=0, 6 beats offered -> 4 accepted, tready=0, level=4; ack=1 -> order 0..3, then beats 4,5.
REQ-035 SHALL cover: steady stream with ack=1 every cycle -> throughput 1 beat/cycle, level stays 1, no gaps after first.
REQ-036 SHALL cover: full FIFO, push offered same cycle as pop -> push rejected that cycle, accepted next, level 4->3->4.
REQ-037 SHALL cover: macro defined, accID=2, beats tdest 2,5,2 -> 2 entries output, drop_count=1; macro undefined -> 3 entries, drop_count=0.
REQ-038 SHALL cover: aresetn low for one cycle with level=3 -> vld=0, level=0, tready=1 next cycle; prior entries never output.
